// File: rtl/barrel_pipe.sv
// barrel_pipe: pipelined logical/arithmetic/rotate barrel shifter.
// One register stage per shift-amount bit; stage k moves the operand by 2^k
// when its amount bit is set. Valid, data, mode, running carry and the
// not-yet-consumed amount bits travel together down the pipe. The whole
// pipe advances in lock-step whenever the output slot is free or drained.
module barrel_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [2:0]       shift_type,
    input  logic [SHW-1:0]   shift,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    // Modes 101..111 are reserved and behave as a plain pass-through.
    function automatic logic is_reserved(input logic [2:0] m);
        return m[2] & (m[1] | m[0]);
    endfunction

    // Global stall: every stage moves only when the final slot can be vacated.
    logic advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int D  = 1 << k;    // distance moved by this stage
        localparam int AW = SHW - k;   // amount bits still pending at this stage

        logic                    prv_vld;
        logic [WIDTH-1:0]        prv_data;
        logic signed [WIDTH-1:0] prv_sdata;
        logic [2:0]              prv_mode;
        logic                    prv_carry;
        logic [AW-1:0]           amt_cur;

        logic [WIDTH-1:0]        data_d;
        logic                    carry_d;

        logic                    vld_q;
        logic [WIDTH-1:0]        data_q;
        logic [2:0]              mode_q;
        logic                    carry_q;

        if (k == 0) begin : g_src
            assign prv_vld   = in_valid;
            assign prv_data  = data_in;
            assign prv_mode  = shift_type;
            assign prv_carry = 1'b0;
            assign amt_cur   = shift;
        end else begin : g_src
            // Remaining amount bits ride in the same slot as stage k-1's data.
            logic [AW-1:0] amt_q;

            // Capture the upper amount bits that stage k-1 did not consume.
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    amt_q <= '0;
                end else if (advance) begin
                    amt_q <= g_stage[k-1].amt_cur[AW:1];
                end
            end

            assign prv_vld   = g_stage[k-1].vld_q;
            assign prv_data  = g_stage[k-1].data_q;
            assign prv_mode  = g_stage[k-1].mode_q;
            assign prv_carry = g_stage[k-1].carry_q;
            assign amt_cur   = amt_q;
        end

        assign prv_sdata = prv_data;

        // Move by 2^k when this stage's amount bit is set; the carry becomes
        // the last bit that left (or, for rotates, the bit that wrapped).
        always_comb begin
            data_d  = prv_data;
            carry_d = prv_carry;
            if (amt_cur[0]) begin
                case (prv_mode)
                    MODE_LSL: begin
                        data_d  = prv_data << D;
                        carry_d = prv_data[WIDTH-D];
                    end
                    MODE_LSR: begin
                        data_d  = prv_data >> D;
                        carry_d = prv_data[D-1];
                    end
                    MODE_ASR: begin
                        data_d  = $unsigned(prv_sdata >>> D);
                        carry_d = prv_data[D-1];
                    end
                    MODE_ROR: begin
                        data_d  = (prv_data >> D) | (prv_data << (WIDTH - D));
                        carry_d = prv_data[D-1];
                    end
                    MODE_ROL: begin
                        data_d  = (prv_data << D) | (prv_data >> (WIDTH - D));
                        carry_d = prv_data[WIDTH-D];
                    end
                    default: begin
                        data_d  = prv_data;
                        carry_d = prv_carry;
                    end
                endcase
            end
        end

        // Stage register: loads from the predecessor on advance, holds otherwise.
        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                vld_q   <= 1'b0;
                data_q  <= '0;
                mode_q  <= '0;
                carry_q <= 1'b0;
            end else if (advance) begin
                vld_q   <= prv_vld;
                data_q  <= data_d;
                mode_q  <= prv_mode;
                carry_q <= carry_d;
            end
        end
    end

    assign out_valid = g_stage[SHW-1].vld_q;
    assign data_out  = g_stage[SHW-1].data_q;
    // Reserved modes never report a carry, whatever the amount.
    assign carry_out = g_stage[SHW-1].carry_q & ~is_reserved(g_stage[SHW-1].mode_q);
    assign zero      = (g_stage[SHW-1].data_q == '0);

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

endmodule

// File: tb/tb_barrel_pipe.sv
// tb_barrel_pipe: directed bench for barrel_pipe at WIDTH=16 with a result
// scoreboard fed at operand acceptance and drained by an output monitor.
module tb_barrel_pipe;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [2:0]  shift_type = 3'b000;
    logic [3:0]  shift = 4'd0;
    logic [15:0] data_in = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_out;
    logic        carry_out;
    logic        zero;
    logic        out_valid;
    logic        out_ready = 1'b1;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    barrel_pipe #(.WIDTH(16)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .shift_type(shift_type),
        .shift     (shift),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .carry_out (carry_out),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clock = ~Clock;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Whole-amount reference shifter.
    function automatic exp_t model(input logic [2:0] m, input logic [3:0] s, input logic [15:0] x);
        exp_t r;
        logic signed [15:0] xs;
        logic [3:0] up;
        logic [3:0] lo;
        xs  = x;
        up  = ~s + 4'd1;
        lo  = s - 4'd1;
        r.d = x;
        r.c = 1'b0;
        if (s != 4'd0) begin
            case (m)
                3'b000: begin r.d = x << s; r.c = x[up]; end
                3'b001: begin r.d = x >> s; r.c = x[lo]; end
                3'b010: begin r.d = $unsigned(xs >>> s); r.c = x[lo]; end
                3'b011: begin r.d = (x >> s) | (x << (5'd16 - {1'b0, s})); r.c = r.d[15]; end
                3'b100: begin r.d = (x << s) | (x >> (5'd16 - {1'b0, s})); r.c = r.d[0]; end
                default: begin r.d = x; r.c = 1'b0; end
            endcase
        end
        return r;
    endfunction

    // Output monitor: every handshaken result must match the oldest expectation.
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Resetn && out_valid && out_ready) begin
            chk1("unexpected_output", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk16("data_out", data_out, e.d);
                chk1("carry_out", carry_out, e.c);
                chk1("zero", zero, e.d == 16'h0000);
            end
        end
    end

    // Present an operand and hold it until accepted; records the expectation.
    task automatic send(input logic [2:0] m, input logic [3:0] s, input logic [15:0] d,
                        input exp_t e, output int waited);
        bit acc;
        shift_type = m;
        shift      = s;
        data_in    = d;
        in_valid   = 1'b1;
        waited     = 0;
        acc        = 1'b0;
        while (!acc && waited < 50) begin
            @(negedge Clock);
            acc = in_ready;
            @(posedge Clock);
            #1;
            if (!acc) waited++;
        end
        chk1("accept", acc, 1'b1);
        if (acc) sb.push_back(e);
    endtask

    // Single isolated operand with the latency counted from acceptance.
    task automatic one(input logic [2:0] m, input logic [3:0] s, input logic [15:0] d,
                       input logic [15:0] ed, input logic ec);
        exp_t e;
        int w;
        int lat;
        e.d = ed;
        e.c = ec;
        send(m, s, d, e, w);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        chkint("latency", lat, 4);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int w;
        int wsum;
        logic [2:0] alt_mode [3];
        exp_t held;

        alt_mode[0] = 3'b000;
        alt_mode[1] = 3'b011;
        alt_mode[2] = 3'b010;

        // Reset state
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_data_out", data_out, 16'h0000);
        chk1("rst_carry_out", carry_out, 1'b0);
        chk1("rst_zero", zero, 1'b1);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // Directed vectors, one at a time
        one(3'b000, 4'd1,  16'hF0F0, 16'hE1E0, 1'b1);
        one(3'b001, 4'd4,  16'hF0F0, 16'h0F0F, 1'b0);
        one(3'b010, 4'd4,  16'h8080, 16'hF808, 1'b0);
        one(3'b010, 4'd0,  16'h8080, 16'h8080, 1'b0);
        one(3'b011, 4'd4,  16'hF0F0, 16'h0F0F, 1'b0);
        one(3'b011, 4'd15, 16'h8080, 16'h0101, 1'b0);
        one(3'b100, 4'd1,  16'h8080, 16'h0101, 1'b1);
        one(3'b000, 4'd1,  16'h8000, 16'h0000, 1'b1);
        one(3'b101, 4'd5,  16'h1234, 16'h1234, 1'b0);
        one(3'b111, 4'd3,  16'hABCD, 16'hABCD, 1'b0);
        one(3'b001, 4'd1,  16'h0001, 16'h0000, 1'b1);
        one(3'b010, 4'd3,  16'h7000, 16'h0E00, 1'b0);
        one(3'b100, 4'd4,  16'h1234, 16'h2341, 1'b1);
        one(3'b000, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0);
        repeat (2) @(posedge Clock);
        #1;

        // Backpressure: stall after the first operand, then drain
        out_ready = 1'b1;
        held = model(3'b000, 4'd4, 16'h00FF);
        send(3'b000, 4'd4, 16'h00FF, held, w);
        out_ready = 1'b0;
        send(3'b001, 4'd3, 16'hC3A5, model(3'b001, 4'd3, 16'hC3A5), w);
        send(3'b011, 4'd9, 16'h1357, model(3'b011, 4'd9, 16'h1357), w);
        send(3'b010, 4'd7, 16'h9ACE, model(3'b010, 4'd7, 16'h9ACE), w);
        shift_type = 3'b100;
        shift      = 4'd5;
        data_in    = 16'h2468;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk1("stall_in_ready", in_ready, 1'b0);
            chk1("stall_out_valid", out_valid, 1'b1);
            chk16("stall_hold_data", data_out, held.d);
            chk1("stall_hold_carry", carry_out, held.c);
            chk1("stall_hold_zero", zero, held.d == 16'h0000);
            @(posedge Clock);
            #1;
        end
        out_ready = 1'b1;
        send(3'b100, 4'd5, 16'h2468, model(3'b100, 4'd5, 16'h2468), w);
        send(3'b000, 4'd12, 16'hFFFF, model(3'b000, 4'd12, 16'hFFFF), w);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge Clock);
            #1;
        end
        chkint("stall_drained", sb.size(), 0);
        repeat (2) @(posedge Clock);
        #1;

        // Reset with operands in flight
        send(3'b000, 4'd2, 16'h1111, model(3'b000, 4'd2, 16'h1111), w);
        send(3'b001, 4'd5, 16'h2222, model(3'b001, 4'd5, 16'h2222), w);
        send(3'b011, 4'd1, 16'h3333, model(3'b011, 4'd1, 16'h3333), w);
        in_valid = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk16("midrst_data_out", data_out, 16'h0000);
        sb.delete();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock);
            #1;
            chk1("post_rst_no_stale", out_valid, 1'b0);
        end
        one(3'b100, 4'd3, 16'h8001, 16'h000C, 1'b0);
        repeat (2) @(posedge Clock);
        #1;

        // Alternating modes, one operand per cycle
        wsum = 0;
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  s;
            logic [15:0] d;
            s = 4'((i * 7 + 1) % 16);
            d = 16'($urandom);
            send(alt_mode[i % 3], s, d, model(alt_mode[i % 3], s, d), w);
            wsum += w;
        end
        in_valid = 1'b0;
        chkint("alt_throughput_waits", wsum, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge Clock);
            #1;
        end
        chkint("alt_drained", sb.size(), 0);

        repeat (3) @(posedge Clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
